// File: rtl/mips_cpu_mult_div.sv
// Multiply/divide unit owning the MIPS HI/LO pair: shift-add multiply and restoring divide
// on operand magnitudes, with the sign fix-up applied when the result is written.
module mips_cpu_mult_div #(
    parameter int WIDTH     = 32,
    parameter bit FAST_MULT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FINISH} state_t;

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opnd;
    logic [WIDTH-1:0]   r_a_raw;
    logic [2*WIDTH-1:0] r_acc;
    logic [CW-1:0]      r_cnt;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic               r_done;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
        return en ? -v : v;
    endfunction

    logic               w_start;
    logic               w_signed;
    logic               w_fast;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [2*WIDTH-1:0] w_fast_prod;
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_next;
    logic [WIDTH:0]     w_div_rem_sh;
    logic [WIDTH:0]     w_div_trial;
    logic [2*WIDTH-1:0] w_div_next;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    assign w_start     = (r_state == S_IDLE) && start;
    assign w_signed    = ~op[0];
    assign w_fast      = FAST_MULT && !op[1];
    assign w_mag_a     = neg_w(op_a, w_signed & op_a[WIDTH-1]);
    assign w_mag_b     = neg_w(op_b, w_signed & op_b[WIDTH-1]);
    assign w_fast_prod = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};

    // Multiply step: r_acc = {partial upper, remaining multiplier bits}, r_opnd = multiplicand.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: r_acc = {partial remainder, dividend/quotient bits}, r_opnd = divisor.
    assign w_div_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    assign w_div_trial  = w_div_rem_sh - {1'b0, r_opnd};
    assign w_div_next   = w_div_trial[WIDTH]
                        ? {w_div_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                        : {w_div_trial[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

    assign w_prod = neg_2w(r_acc, r_neg_q);
    assign w_quo  = neg_w(r_acc[WIDTH-1:0], r_neg_q);
    assign w_rem  = neg_w(r_acc[2*WIDTH-1:WIDTH], r_neg_r);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_start && !op[2]) w_next = w_fast ? S_FINISH : S_RUN;
            S_RUN:    if (r_cnt == CW'(WIDTH-1)) w_next = S_FINISH;
            S_FINISH: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_opnd   <= '0;
            r_a_raw  <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_div0   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: if (w_start) begin
                    case (op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            r_a_raw  <= op_a;
                            r_opnd   <= op[1] ? w_mag_b : w_mag_a;
                            r_acc    <= w_fast ? w_fast_prod
                                               : {{WIDTH{1'b0}}, (op[1] ? w_mag_a : w_mag_b)};
                            r_cnt    <= '0;
                            r_is_div <= op[1];
                            r_neg_q  <= w_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                            r_neg_r  <= w_signed & op_a[WIDTH-1];
                            r_div0   <= op[1] & (op_b == '0);
                        end
                        3'd4: begin
                            r_hi   <= op_a;
                            r_done <= 1'b1;
                        end
                        3'd5: begin
                            r_lo   <= op_a;
                            r_done <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + CW'(1);
                end
                S_FINISH: begin
                    r_done <= 1'b1;
                    // Divide by zero keeps the raw dividend in HI; no sign fix-up.
                    if (r_is_div && r_div0) begin
                        r_hi <= r_a_raw;
                        r_lo <= '1;
                    end else if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;
endmodule
